// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM states
// and the forwarding-source priority rule.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        REG = 2'd0,
        MEM = 2'd1,
        WB  = 2'd2
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        HALT    = 2'd2
    } hz_state_t;

    // The youngest producer (MEM) wins over WB. Register 0 gets no special treatment.
    function automatic fwd_sel_t fwd_pick(
        input logic [2:0] src,
        input logic [2:0] mem_rd,
        input logic       mem_we,
        input logic [2:0] wb_rd,
        input logic       wb_we
    );
        if (mem_we && (mem_rd == src)) return MEM;
        if (wb_we && (wb_rd == src))   return WB;
        return REG;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// Saturating event counter used for the optional stall/flush statistics.
module pipe_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the five-stage pipeline: stall/flush/hold control, EX forwarding
// selects and multi-cycle op handshake. Define PIPE_CTRL_PERF_EN for stall/flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 16
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] id_rs_a,
    input  logic [2:0] id_rs_b,
    input  logic       id_uses_a,
    input  logic       id_uses_b,
    input  logic [2:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [2:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [2:0] wb_rd,
    input  logic       wb_reg_write,
    input  logic       ex_branch_taken,
    input  logic       ex_mc_op,
    input  logic       mc_done,
    input  logic       mc_error,
    input  logic       mem_halt,
    output logic       pc_hold,
    output logic       if_id_hold,
    output logic       id_ex_hold,
    output logic       if_id_bubble,
    output logic       id_ex_bubble,
    output logic       ex_mem_bubble,
    output logic       mc_go,
    output fwd_sel_t   fwd_a_sel,
    output fwd_sel_t   fwd_b_sel,
    output logic       halted,
    output logic       err_sticky
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int TO_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;

    hz_state_t       r_state;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_mc_go;
    logic            r_err;

    logic w_load_use;
    logic w_run_free;
    logic w_flush;
    logic w_stall;
    logic w_to_last;

    assign w_load_use = ex_mem_read & ex_reg_write &
                        ((id_uses_a & (ex_rd == id_rs_a)) |
                         (id_uses_b & (ex_rd == id_rs_b)));

    // Halt and multi-cycle start outrank both flush and load-use in RUN.
    assign w_run_free = (r_state == RUN) & ~mem_halt & ~ex_mc_op;
    assign w_flush    = w_run_free & ex_branch_taken;
    assign w_stall    = w_run_free & ~ex_branch_taken & w_load_use;
    assign w_to_last  = (r_to_cnt == TO_W'(MC_TIMEOUT - 1));

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        pc_hold       = 1'b0;
        if_id_hold    = 1'b0;
        id_ex_hold    = 1'b0;
        if_id_bubble  = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if (reset_n) begin
            case (r_state)
                RUN: begin
                    if (w_flush) begin
                        if_id_bubble = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                    if (w_stall) begin
                        pc_hold      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                MC_WAIT: begin
                    pc_hold       = 1'b1;
                    if_id_hold    = 1'b1;
                    id_ex_hold    = 1'b1;
                    ex_mem_bubble = 1'b1;
                end
                HALT: begin
                    pc_hold    = 1'b1;
                    if_id_hold = 1'b1;
                    id_ex_hold = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= RUN;
            r_to_cnt <= '0;
            r_mc_go  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_mc_go <= 1'b0;
            case (r_state)
                RUN: begin
                    if (mem_halt) begin
                        r_state <= HALT;
                    end else if (ex_mc_op) begin
                        r_state  <= MC_WAIT;
                        r_to_cnt <= '0;
                        r_mc_go  <= 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (mc_done) begin
                        r_state <= RUN;
                        if (mc_error) r_err <= 1'b1;
                    end else if (w_to_last) begin
                        r_state <= RUN;
                        r_err   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                HALT:    r_state <= HALT;
                default: r_state <= RUN;
            endcase
        end
    end

    assign mc_go      = r_mc_go;
    assign halted     = (r_state == HALT);
    assign err_sticky = r_err;
    assign fwd_a_sel  = fwd_pick(id_rs_a, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    assign fwd_b_sel  = fwd_pick(id_rs_b, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

`ifdef PIPE_CTRL_PERF_EN
    logic w_stall_evt;

    assign w_stall_evt = (pc_hold | if_id_hold | id_ex_hold) & (r_state != HALT);

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_stall_evt),
        .o_cnt   (stall_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_flush),
        .o_cnt   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int TO = 6;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] id_rs_a, id_rs_b, ex_rd, mem_rd, wb_rd;
    logic       id_uses_a, id_uses_b, ex_reg_write, ex_mem_read;
    logic       mem_reg_write, wb_reg_write, ex_branch_taken, ex_mc_op;
    logic       mc_done, mc_error, mem_halt;
    logic       pc_hold, if_id_hold, id_ex_hold;
    logic       if_id_bubble, id_ex_bubble, ex_mem_bubble;
    logic       mc_go, halted, err_sticky;
    logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
    int unsigned m_stall, m_flush;
`endif

    int checks = 0;
    int errors = 0;

    bit m_halt, m_mc, m_go, m_err;
    int m_wait;
    bit e_any_hold, e_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MC_TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_rs_a         (id_rs_a),
        .id_rs_b         (id_rs_b),
        .id_uses_a       (id_uses_a),
        .id_uses_b       (id_uses_b),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .mem_rd          (mem_rd),
        .mem_reg_write   (mem_reg_write),
        .wb_rd           (wb_rd),
        .wb_reg_write    (wb_reg_write),
        .ex_branch_taken (ex_branch_taken),
        .ex_mc_op        (ex_mc_op),
        .mc_done         (mc_done),
        .mc_error        (mc_error),
        .mem_halt        (mem_halt),
        .pc_hold         (pc_hold),
        .if_id_hold      (if_id_hold),
        .id_ex_hold      (id_ex_hold),
        .if_id_bubble    (if_id_bubble),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_bubble   (ex_mem_bubble),
        .mc_go           (mc_go),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .halted          (halted),
        .err_sticky      (err_sticky)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [2:0] src);
        if (mem_reg_write && mem_rd == src) return 2'd1;
        if (wb_reg_write && wb_rd == src)   return 2'd2;
        return 2'd0;
    endfunction

    task automatic clear_inputs();
        {id_rs_a, id_rs_b, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_a, id_uses_b, ex_reg_write, ex_mem_read} = '0;
        {mem_reg_write, wb_reg_write, ex_branch_taken, ex_mc_op} = '0;
        {mc_done, mc_error, mem_halt} = '0;
    endtask

    // Expected outputs follow the written rules: halted holds everything, waiting on the
    // multi-cycle unit holds the front end and drains MEM, otherwise halt > mc > branch > load-use.
    task automatic check_all();
        bit lu, ph, ifh, idh, ifb, idb, exb;
        lu = ex_mem_read && ex_reg_write &&
             ((id_uses_a && ex_rd == id_rs_a) || (id_uses_b && ex_rd == id_rs_b));
        {ph, ifh, idh, ifb, idb, exb} = '0;
        e_flush = 1'b0;
        if (m_halt) begin
            {ph, ifh, idh} = 3'b111;
        end else if (m_mc) begin
            {ph, ifh, idh, exb} = 4'b1111;
        end else if (!mem_halt && !ex_mc_op) begin
            if (ex_branch_taken) begin
                {ifb, idb} = 2'b11;
                e_flush = 1'b1;
            end else if (lu) begin
                {ph, ifh, idb} = 3'b111;
            end
        end
        e_any_hold = !m_halt && (ph || ifh || idh);
        check("pc_hold",       32'(pc_hold),       32'(ph));
        check("if_id_hold",    32'(if_id_hold),    32'(ifh));
        check("id_ex_hold",    32'(id_ex_hold),    32'(idh));
        check("if_id_bubble",  32'(if_id_bubble),  32'(ifb));
        check("id_ex_bubble",  32'(id_ex_bubble),  32'(idb));
        check("ex_mem_bubble", 32'(ex_mem_bubble), 32'(exb));
        check("mc_go",         32'(mc_go),         32'(m_go));
        check("halted",        32'(halted),        32'(m_halt));
        check("err_sticky",    32'(err_sticky),    32'(m_err));
        check("fwd_a_sel",     32'(fwd_a_sel),     32'(exp_fwd(id_rs_a)));
        check("fwd_b_sel",     32'(fwd_b_sel),     32'(exp_fwd(id_rs_b)));
`ifdef PIPE_CTRL_PERF_EN
        check("stall_cnt",     32'(stall_cnt),     m_stall);
        check("flush_cnt",     32'(flush_cnt),     m_flush);
`endif
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    task automatic advance();
`ifdef PIPE_CTRL_PERF_EN
        if (e_any_hold && m_stall < 32'hFFFF) m_stall++;
        if (e_flush && m_flush < 32'hFFFF)    m_flush++;
`endif
        if (m_mc) begin
            m_go = 1'b0;
            if (mc_done) begin
                m_mc = 1'b0;
                if (mc_error) m_err = 1'b1;
            end else if (m_wait + 1 == TO) begin
                m_mc  = 1'b0;
                m_err = 1'b1;
            end else begin
                m_wait++;
            end
        end else if (!m_halt) begin
            m_go = 1'b0;
            if (mem_halt) begin
                m_halt = 1'b1;
            end else if (ex_mc_op) begin
                m_mc   = 1'b1;
                m_wait = 0;
                m_go   = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic model_reset();
        {m_halt, m_mc, m_go, m_err} = '0;
        m_wait = 0;
`ifdef PIPE_CTRL_PERF_EN
        m_stall = 0;
        m_flush = 0;
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        model_reset();
        #2;
        check("rst_halted", 32'(halted),     32'd0);
        check("rst_holds",  32'({pc_hold, if_id_hold, id_ex_hold}), 32'd0);
        check("rst_mc_go",  32'(mc_go),      32'd0);
        check("rst_err",    32'(err_sticky), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("por_outputs", 32'({pc_hold, if_id_hold, id_ex_hold, if_id_bubble, id_ex_bubble,
                                  ex_mem_bubble, mc_go, halted, err_sticky}), 32'd0);
        do_reset();

        // Load-use on r3, then the load moves to MEM and feeds operand A.
        ex_rd = 3'd3; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        id_rs_a = 3'd3; id_uses_a = 1'b1;
        settle();
        check("lu_stall", 32'({pc_hold, if_id_hold, id_ex_bubble, id_ex_hold}), 32'b1110);
        advance();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        mem_rd = 3'd3; mem_reg_write = 1'b1;
        settle();
        check("lu_release", 32'({pc_hold, if_id_hold, id_ex_bubble}), 32'd0);
        check("lu_fwd_mem", 32'(fwd_a_sel), 32'd1);
        advance();

        // Taken branch coinciding with a load-use: flush wins.
        clear_inputs();
        ex_rd = 3'd5; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        id_rs_b = 3'd5; id_uses_b = 1'b1; ex_branch_taken = 1'b1;
        settle();
        check("br_flush", 32'({if_id_bubble, id_ex_bubble, pc_hold, if_id_hold}), 32'b1100);
        advance();

        // Multi-cycle op completing in the fifth wait cycle.
        clear_inputs();
        ex_mc_op = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            mc_done = (i == 4);
            settle();
            check("mc_hold", 32'({pc_hold, id_ex_hold, ex_mem_bubble}), 32'b111);
            check("mc_go_once", 32'(mc_go), (i == 0) ? 32'd1 : 32'd0);
            advance();
        end
        clear_inputs();
        settle();
        check("mc_back_run", 32'({pc_hold, err_sticky}), 32'd0);
        advance();

        // Multi-cycle op with no done: timeout after TO wait cycles.
        ex_mc_op = 1'b1;
        step();
        for (int i = 0; i < TO; i++) begin
            mc_done = 1'b0;
            step();
        end
        clear_inputs();
        settle();
        check("to_back_run", 32'({pc_hold, err_sticky}), 32'b01);
        advance();

        // Forwarding priority: MEM beats WB, WB alone selects WB.
        id_rs_a = 3'd2; id_rs_b = 3'd2; id_uses_a = 1'b1;
        mem_rd = 3'd2; wb_rd = 3'd2; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        settle();
        check("fwd_mem_prio", 32'(fwd_a_sel), 32'd1);
        advance();
        mem_reg_write = 1'b0;
        settle();
        check("fwd_wb_only", 32'(fwd_b_sel), 32'd2);
        advance();
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            id_rs_a         = 3'($urandom_range(0, 7));
            id_rs_b         = 3'($urandom_range(0, 7));
            ex_rd           = 3'($urandom_range(0, 7));
            mem_rd          = 3'($urandom_range(0, 7));
            wb_rd           = 3'($urandom_range(0, 7));
            id_uses_a       = 1'($urandom_range(0, 1));
            id_uses_b       = 1'($urandom_range(0, 1));
            ex_reg_write    = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            mem_reg_write   = 1'($urandom_range(0, 1));
            wb_reg_write    = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            ex_mc_op        = ($urandom_range(0, 7) == 0);
            mc_done         = ($urandom_range(0, 4) == 0);
            mc_error        = 1'($urandom_range(0, 1));
            mem_halt        = ($urandom_range(0, 79) == 0);
            step();
            if (m_halt && $urandom_range(0, 7) == 0) do_reset();
        end
        do_reset();

        // Halt, then asynchronous reset in the middle of HALT.
        mem_halt = 1'b1;
        step();
        mem_halt = 1'b0;
        settle();
        check("halt_state", 32'({halted, pc_hold, if_id_hold, id_ex_hold, if_id_bubble}), 32'b11110);
        advance();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("halt_rst_async", 32'({halted, pc_hold, if_id_hold, id_ex_hold}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        ex_branch_taken = 1'b1;
        settle();
        check("post_rst_run", 32'({if_id_bubble, id_ex_bubble, halted}), 32'b110);
        advance();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
